controller: RTL and testbench

- Control unit of the multicycle MIPS CPU.
- A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives the datapath's mux selects, write enables and ALU control from the opcode, the R-type function field and the ALU zero flag.
- Supports lw, sw, R-type (add, sub, and, or, slt), beq, addi and j.

---
 rtl/controller_if.sv | 40 ++++
 rtl/controller.sv | 166 ++++++++++++++++
 tb/tb_controller.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : controller_if                                          |
// | Description : Control bundle between the multicycle MIPS controller  |
// |               and its datapath. The controller reads the opcode,     |
// |               function field and ALU zero flag. It returns the mux   |
// |               selects, the write enables and the ALU operation.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface controller_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pcen;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic       alusrca;
   logic       iord;
   logic       memtoreg;
   logic       regdst;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [2:0] alucontrol;

   // Controller side: consumes instruction fields, drives control lines
   modport master (
      input  op, funct, zero,
      output pcen, memwrite, irwrite, regwrite, alusrca, iord,
             memtoreg, regdst, alusrcb, pcsrc, alucontrol
   );

   // Datapath side: supplies instruction fields, obeys control lines
   modport slave (
      output op, funct, zero,
      input  pcen, memwrite, irwrite, regwrite, alusrca, iord,
             memtoreg, regdst, alusrcb, pcsrc, alucontrol
   );
endinterface
`default_nettype wire

// File: rtl/controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : controller                                             |
// | Description : Moore FSM control unit for the multicycle MIPS CPU.    |
// |               It steps each instruction through fetch, decode,       |
// |               execute, memory and writeback. It decodes the ALU      |
// |               operation from the opcode class and the funct field.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module controller (
   input  logic         clk,
   input  logic         reset,
   controller_if.master bus
);

   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;
   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_j     = 6'b000010;

   typedef enum logic [3:0] {
      c_fetch    = 4'd0,
      c_decode   = 4'd1,
      c_memadr   = 4'd2,
      c_memrd    = 4'd3,
      c_memwb    = 4'd4,
      c_memwr    = 4'd5,
      c_execute  = 4'd6,
      c_aluwb    = 4'd7,
      c_branch   = 4'd8,
      c_addiexec = 4'd9,
      c_addiwb   = 4'd10,
      c_jump     = 4'd11
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic       w_pcwrite;
   logic       w_branch;
   logic [1:0] w_aluop;

   // State register; reset drops the FSM into fetch without waiting for a clock edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_fetch;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state selection and Moore control outputs for the current state
   always_comb begin
      w_next       = c_fetch;
      w_pcwrite    = 1'b0;
      w_branch     = 1'b0;
      w_aluop      = 2'b00;
      bus.memwrite = 1'b0;
      bus.irwrite  = 1'b0;
      bus.regwrite = 1'b0;
      bus.alusrca  = 1'b0;
      bus.iord     = 1'b0;
      bus.memtoreg = 1'b0;
      bus.regdst   = 1'b0;
      bus.alusrcb  = 2'b00;
      bus.pcsrc    = 2'b00;
      case (r_state)
         c_fetch: begin
            bus.alusrcb = 2'b01;
            bus.irwrite = 1'b1;
            w_pcwrite   = 1'b1;
            w_next      = c_decode;
         end
         c_decode: begin
            // Branch target is precomputed here while the opcode is decoded
            bus.alusrcb = 2'b11;
            case (bus.op)
               c_op_lw, c_op_sw: w_next = c_memadr;
               c_op_rtype:       w_next = c_execute;
               c_op_beq:         w_next = c_branch;
               c_op_addi:        w_next = c_addiexec;
               c_op_j:           w_next = c_jump;
               default:          w_next = c_fetch;
            endcase
         end
         c_memadr: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
            w_next      = (bus.op == c_op_lw) ? c_memrd : c_memwr;
         end
         c_memrd: begin
            bus.iord = 1'b1;
            w_next   = c_memwb;
         end
         c_memwb: begin
            bus.memtoreg = 1'b1;
            bus.regwrite = 1'b1;
            w_next       = c_fetch;
         end
         c_memwr: begin
            bus.iord     = 1'b1;
            bus.memwrite = 1'b1;
            w_next       = c_fetch;
         end
         c_execute: begin
            bus.alusrca = 1'b1;
            w_aluop     = 2'b10;
            w_next      = c_aluwb;
         end
         c_aluwb: begin
            bus.regdst   = 1'b1;
            bus.regwrite = 1'b1;
            w_next       = c_fetch;
         end
         c_branch: begin
            bus.alusrca = 1'b1;
            w_aluop     = 2'b01;
            bus.pcsrc   = 2'b01;
            w_branch    = 1'b1;
            w_next      = c_fetch;
         end
         c_addiexec: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
            w_next      = c_addiwb;
         end
         c_addiwb: begin
            bus.regwrite = 1'b1;
            w_next       = c_fetch;
         end
         c_jump: begin
            bus.pcsrc = 2'b10;
            w_pcwrite = 1'b1;
            w_next    = c_fetch;
         end
         default: begin
            w_next = c_fetch;
         end
      endcase
   end

   // ALU decoder: add for address/PC math, subtract for beq, funct-driven for R-type
   always_comb begin
      bus.alucontrol = 3'b010;
      case (w_aluop)
         2'b00: bus.alucontrol = 3'b010;
         2'b01: bus.alucontrol = 3'b110;
         default: begin
            case (bus.funct)
               6'b100000: bus.alucontrol = 3'b010;
               6'b100010: bus.alucontrol = 3'b110;
               6'b100100: bus.alucontrol = 3'b000;
               6'b100101: bus.alucontrol = 3'b001;
               6'b101010: bus.alucontrol = 3'b111;
               default:   bus.alucontrol = 3'b010;
            endcase
         end
      endcase
   end

   // PC write: unconditional in fetch/jump, taken-branch only when the compare hit zero
   assign bus.pcen = w_pcwrite | (w_branch & bus.zero);

endmodule
`default_nettype wire

// File: tb/tb_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_controller                                          |
// | Description : Self-checking bench for the multicycle MIPS controller.|
// |               It uses directed instruction vectors and reset         |
// |               sequences, then a random instruction stream checked    |
// |               against a per-instruction cycle-list model.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_controller;

   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;
   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_j     = 6'b000010;
   localparam logic [5:0] c_op_bad   = 6'b111111;

   // One expected cycle: output vector plus flags for input-dependent fields
   typedef struct {
      logic [14:0] exp;
      bit          alu_funct;
      bit          pcen_zero;
   } step_t;

   // Directed vector: instruction inputs and the observable results it must give
   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [5:0]  funct;
      int          zmode;
      int          cpi;
      logic [2:0]  alu3;
      logic        pcen3;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   int          checks = 0;
   int          errors = 0;
   step_t       exp_q[$];
   logic [5:0]  functs [0:4];
   vec_t        vt [0:12];

   controller_if bus ();

   controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Outputs packed as {pcen,memwrite,irwrite,regwrite,alusrca,iord,memtoreg,regdst,alusrcb,pcsrc,alucontrol}
   logic [14:0] w_outs;
   assign w_outs = {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.alusrca,
                    bus.iord, bus.memtoreg, bus.regdst, bus.alusrcb, bus.pcsrc,
                    bus.alucontrol};

   // fl = {pcen,memwrite,irwrite,regwrite,alusrca,iord,memtoreg,regdst}
   function automatic logic [14:0] mk(input logic [7:0] fl, input logic [1:0] sb,
                                      input logic [1:0] ps, input logic [2:0] alu);
      return {fl, sb, ps, alu};
   endfunction

   function automatic logic [2:0] alu_of(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic void add_step(input logic [14:0] e, input bit af, input bit pz);
      step_t s;
      s.exp       = e;
      s.alu_funct = af;
      s.pcen_zero = pz;
      exp_q.push_back(s);
   endfunction

   // Expected cycle list of one instruction, from fetch up to its last cycle
   function automatic void build(input logic [5:0] o);
      exp_q.delete();
      add_step(mk(8'b1010_0000, 2'b01, 2'b00, 3'b010), 1'b0, 1'b0);
      add_step(mk(8'b0000_0000, 2'b11, 2'b00, 3'b010), 1'b0, 1'b0);
      case (o)
         c_op_lw: begin
            add_step(mk(8'b0000_1000, 2'b10, 2'b00, 3'b010), 1'b0, 1'b0);
            add_step(mk(8'b0000_0100, 2'b00, 2'b00, 3'b010), 1'b0, 1'b0);
            add_step(mk(8'b0001_0010, 2'b00, 2'b00, 3'b010), 1'b0, 1'b0);
         end
         c_op_sw: begin
            add_step(mk(8'b0000_1000, 2'b10, 2'b00, 3'b010), 1'b0, 1'b0);
            add_step(mk(8'b0100_0100, 2'b00, 2'b00, 3'b010), 1'b0, 1'b0);
         end
         c_op_rtype: begin
            add_step(mk(8'b0000_1000, 2'b00, 2'b00, 3'b010), 1'b1, 1'b0);
            add_step(mk(8'b0001_0001, 2'b00, 2'b00, 3'b010), 1'b0, 1'b0);
         end
         c_op_beq: begin
            add_step(mk(8'b0000_1000, 2'b00, 2'b01, 3'b110), 1'b0, 1'b1);
         end
         c_op_addi: begin
            add_step(mk(8'b0000_1000, 2'b10, 2'b00, 3'b010), 1'b0, 1'b0);
            add_step(mk(8'b0001_0000, 2'b00, 2'b00, 3'b010), 1'b0, 1'b0);
         end
         c_op_j: begin
            add_step(mk(8'b1000_0000, 2'b00, 2'b10, 3'b010), 1'b0, 1'b0);
         end
         default: ;
      endcase
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", nm, got, exp);
      end
   endtask

   // Runs one instruction starting in fetch; zmode 0/1 = fixed zero, 2 = random zero and funct
   task automatic run_instr(input string nm, input logic [5:0] o, input logic [5:0] f,
                            input int zmode, output int cyc, output logic [14:0] third);
      logic [14:0] e;
      int          k;
      build(o);
      third = '0;
      k     = 0;
      while (1) begin
         bus.op = o;
         if (zmode == 2 && !(k < exp_q.size() && exp_q[k].alu_funct))
            bus.funct = 6'($urandom);
         else
            bus.funct = f;
         bus.zero = (zmode == 2) ? 1'($urandom) : (zmode == 1);
         #1;
         if (k == 2) third = w_outs;
         if (k > 0 && bus.irwrite) break;
         if (k < exp_q.size()) begin
            e = exp_q[k].exp;
            if (exp_q[k].alu_funct) e[2:0] = alu_of(bus.funct);
            if (exp_q[k].pcen_zero) e[14]  = bus.zero;
            check($sformatf("%s op=%b cyc%0d", nm, o, k), 32'(w_outs), 32'(e));
         end else if (k == exp_q.size()) begin
            check($sformatf("%s op=%b return-to-fetch", nm, o), 32'(bus.irwrite), 32'd1);
         end
         if (k >= 12) begin
            $display("FAIL %s op=%b never returned to fetch", nm, o);
            $fatal(1);
         end
         @(posedge clk);
         #1;
         k++;
      end
      cyc = k;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int          cyc;
      logic [14:0] third;
      logic [14:0] fetch_exp;
      logic [14:0] decode_exp;
      logic [5:0]  rop;
      logic [5:0]  rfn;

      fetch_exp  = mk(8'b1010_0000, 2'b01, 2'b00, 3'b010);
      decode_exp = mk(8'b0000_0000, 2'b11, 2'b00, 3'b010);
      functs[0] = 6'b100000; functs[1] = 6'b100010; functs[2] = 6'b100100;
      functs[3] = 6'b100101; functs[4] = 6'b101010;

      vt[0]  = '{"add",     c_op_rtype, 6'b100000, 0, 4, 3'b010, 1'b0};
      vt[1]  = '{"sub",     c_op_rtype, 6'b100010, 0, 4, 3'b110, 1'b0};
      vt[2]  = '{"and",     c_op_rtype, 6'b100100, 0, 4, 3'b000, 1'b0};
      vt[3]  = '{"or",      c_op_rtype, 6'b100101, 0, 4, 3'b001, 1'b0};
      vt[4]  = '{"slt",     c_op_rtype, 6'b101010, 0, 4, 3'b111, 1'b0};
      vt[5]  = '{"rfunct?", c_op_rtype, 6'b111111, 1, 4, 3'b010, 1'b0};
      vt[6]  = '{"lw",      c_op_lw,    6'b100010, 1, 5, 3'b010, 1'b0};
      vt[7]  = '{"sw",      c_op_sw,    6'b100010, 0, 4, 3'b010, 1'b0};
      vt[8]  = '{"addi",    c_op_addi,  6'b101010, 0, 4, 3'b010, 1'b0};
      vt[9]  = '{"beq_nz",  c_op_beq,   6'b100000, 0, 3, 3'b110, 1'b0};
      vt[10] = '{"beq_z",   c_op_beq,   6'b100000, 1, 3, 3'b110, 1'b1};
      vt[11] = '{"j",       c_op_j,     6'b100100, 0, 3, 3'b010, 1'b1};
      vt[12] = '{"badop",   c_op_bad,   6'b100000, 1, 2, 3'b010, 1'b1};

      // Reset held across edges gives fetch outputs; release leads to decode
      reset     = 1'b0;
      bus.op    = c_op_bad;
      bus.funct = 6'b000000;
      bus.zero  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset held fetch", 32'(w_outs), 32'(fetch_exp));
      reset = 1'b1;
      #1;
      check("reset released fetch", 32'(w_outs), 32'(fetch_exp));
      @(posedge clk);
      #1;
      check("decode after release", 32'(w_outs), 32'(decode_exp));
      @(posedge clk);
      #1;
      check("bad op back to fetch", 32'(w_outs), 32'(fetch_exp));

      // Directed instruction table
      for (int i = 0; i < 13; i++) begin
         run_instr(vt[i].name, vt[i].op, vt[i].funct, vt[i].zmode, cyc, third);
         check({vt[i].name, " cpi"}, 32'(cyc), 32'(vt[i].cpi));
         check({vt[i].name, " alucontrol cyc2"}, 32'(third[2:0]), 32'(vt[i].alu3));
         check({vt[i].name, " pcen cyc2"}, 32'(third[14]), 32'(vt[i].pcen3));
      end

      // Reset in the middle of lw aborts straight to fetch, asynchronously
      bus.op = c_op_lw;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("lw memadr before abort", 32'(w_outs), 32'(mk(8'b0000_1000, 2'b10, 2'b00, 3'b010)));
      reset = 1'b0;
      #1;
      check("async abort to fetch", 32'(w_outs), 32'(fetch_exp));
      @(posedge clk);
      #1;
      check("fetch held in reset", 32'(w_outs), 32'(fetch_exp));
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("decode after abort", 32'(w_outs), 32'(decode_exp));
      bus.op = c_op_bad;
      @(posedge clk);
      #1;
      check("fetch after abort decode", 32'(w_outs), 32'(fetch_exp));

      // Random instruction stream, zero and out-of-execute funct toggling every cycle
      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 6))
            0: rop = c_op_lw;
            1: rop = c_op_sw;
            2: rop = c_op_rtype;
            3: rop = c_op_beq;
            4: rop = c_op_addi;
            5: rop = c_op_j;
            default: rop = 6'($urandom);
         endcase
         if ($urandom_range(0, 5) == 5) rfn = 6'($urandom);
         else rfn = functs[$urandom_range(0, 4)];
         run_instr($sformatf("rand%0d", n), rop, rfn, 2, cyc, third);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
